// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port between two masters.
// Byte-enabled partial writes are turned into a two-cycle read-modify-write.
module mem_port_arbiter #(
    parameter int DATA = 32,
    parameter int ADDR = 10,
    parameter int BE   = DATA / 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [BE-1:0]   m0_be,
    input  logic [ADDR-1:0] m0_addr,
    input  logic [DATA-1:0] m0_wdata,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DATA-1:0] m0_rdata,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [BE-1:0]   m1_be,
    input  logic [ADDR-1:0] m1_addr,
    input  logic [DATA-1:0] m1_wdata,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DATA-1:0] m1_rdata,
    output logic            ram_wr,
    output logic [ADDR-1:0] ram_addr,
    output logic [DATA-1:0] ram_din,
    input  logic [DATA-1:0] ram_dout
);

    typedef enum logic {IDLE, MERGE} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_last;
    logic [ADDR-1:0] r_addr, r_maddr;
    logic [DATA-1:0] r_din, r_mwdata, r_rdata0, r_rdata1;
    logic [BE-1:0]   r_mbe;
    logic            r_pend0, r_pend1;

    logic            w_gnt0, w_gnt1, w_any;
    logic            w_we, w_full, w_partial;
    logic [BE-1:0]   w_be;
    logic [ADDR-1:0] w_req_addr, w_addr;
    logic [DATA-1:0] w_req_wdata, w_din, w_merged;
    logic            w_wr, w_rd0, w_rd1;

    // r_last names the master granted most recently; a tie goes to the other one
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst && r_state == IDLE) begin
            if (m0_req && m1_req) begin
                w_gnt0 = r_last;
                w_gnt1 = !r_last;
            end else begin
                w_gnt0 = m0_req;
                w_gnt1 = m1_req;
            end
        end
    end

    assign w_any       = w_gnt0 | w_gnt1;
    assign w_we        = w_gnt1 ? m1_we    : m0_we;
    assign w_be        = w_gnt1 ? m1_be    : m0_be;
    assign w_req_addr  = w_gnt1 ? m1_addr  : m0_addr;
    assign w_req_wdata = w_gnt1 ? m1_wdata : m0_wdata;
    assign w_full      = (w_be == '1);
    assign w_partial   = (w_be != '1) && (w_be != '0);

    always_comb begin
        w_merged = ram_dout;
        for (int unsigned k = 0; k < BE; k++) begin
            if (r_mbe[k]) begin
                w_merged[8*k +: 8] = r_mwdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_addr      = r_addr;
        w_din       = r_din;
        w_rd0       = 1'b0;
        w_rd1       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    if (!w_we) begin
                        w_addr = w_req_addr;
                        w_din  = w_req_wdata;
                        w_rd0  = w_gnt0;
                        w_rd1  = w_gnt1;
                    end else if (w_full) begin
                        w_wr   = 1'b1;
                        w_addr = w_req_addr;
                        w_din  = w_req_wdata;
                    end else if (w_partial) begin
                        w_addr      = w_req_addr;
                        w_din       = w_req_wdata;
                        w_state_nxt = MERGE;
                    end
                end
            end
            MERGE: begin
                w_wr        = 1'b1;
                w_addr      = r_maddr;
                w_din       = w_merged;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // reset abandons any pending merge write and suppresses read issue
        if (rst) begin
            w_wr        = 1'b0;
            w_addr      = r_addr;
            w_din       = r_din;
            w_rd0       = 1'b0;
            w_rd1       = 1'b0;
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_last   <= 1'b1;
            r_addr   <= '0;
            r_din    <= '0;
            r_maddr  <= '0;
            r_mwdata <= '0;
            r_mbe    <= '0;
            r_pend0  <= 1'b0;
            r_pend1  <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr;
            r_din   <= w_din;
            r_pend0 <= w_rd0;
            r_pend1 <= w_rd1;
            if (w_any) begin
                r_last <= w_gnt1;
            end
            if (r_pend0) begin
                r_rdata0 <= ram_dout;
            end
            if (r_pend1) begin
                r_rdata1 <= ram_dout;
            end
            if (r_state == IDLE && w_state_nxt == MERGE) begin
                r_maddr  <= w_req_addr;
                r_mwdata <= w_req_wdata;
                r_mbe    <= w_be;
            end
        end
    end

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign m0_rvalid = r_pend0 & ~rst;
    assign m1_rvalid = r_pend1 & ~rst;
    // read data comes straight from the registered RAM output in the valid cycle
    assign m0_rdata  = m0_rvalid ? ram_dout : r_rdata0;
    assign m1_rdata  = m1_rvalid ? ram_dout : r_rdata1;
    assign ram_wr    = w_wr;
    assign ram_addr  = w_addr;
    assign ram_din   = w_din;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model of the shared memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        q_req   [2];
    logic        q_we    [2];
    logic [3:0]  q_be    [2];
    logic [9:0]  q_addr  [2];
    logic [31:0] q_wdata [2];
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_wr;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    logic        ld_we;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] mem [16];

    int total = 0;
    int bad   = 0;

    logic [31:0] smem [16];
    logic        mbusy;
    int          mlast;
    logic [9:0]  pend_addr;
    logic [31:0] pend_data;
    logic        exp_rv [2];
    logic [31:0] exp_rd [2];
    logic [31:0] hold   [2];

    mem_port_arbiter #(.DATA(32), .ADDR(10)) dut (
        .clk(clk), .rst(rst),
        .m0_req(q_req[0]), .m0_we(q_we[0]), .m0_be(q_be[0]), .m0_addr(q_addr[0]),
        .m0_wdata(q_wdata[0]), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(q_req[1]), .m1_we(q_we[1]), .m1_be(q_be[1]), .m1_addr(q_addr[1]),
        .m1_wdata(q_wdata[1]), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // registered write-first RAM with a loader used only for preloading
    always @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end else if (ram_wr) begin
            mem[ram_addr[3:0]] <= ram_din;
        end
        ram_dout <= ram_wr ? ram_din : mem[ram_addr[3:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int m, input logic we, input logic [3:0] be,
                           input logic [9:0] addr, input logic [31:0] wdata);
        q_req[m] = 1'b1; q_we[m] = we; q_be[m] = be; q_addr[m] = addr; q_wdata[m] = wdata;
    endtask

    task automatic rand_req(input int m);
        logic [3:0] be;
        case ($urandom_range(0, 3))
            0:       be = 4'h0;
            1:       be = 4'hF;
            default: be = 4'($urandom);
        endcase
        set_req(m, 1'($urandom), be, 10'($urandom_range(0, 15)), $urandom);
    endtask

    // one clock: check outputs mid-cycle against the model, then advance the model
    task automatic cycle();
        int          g;
        logic [31:0] mask;
        logic        exp_wr;
        @(negedge clk);
        g = -1;
        if (!rst && !mbusy) begin
            if (q_req[0] && q_req[1]) g = (mlast == 1) ? 0 : 1;
            else if (q_req[0])        g = 0;
            else if (q_req[1])        g = 1;
        end
        chk("gnt0", m0_gnt, (g == 0));
        chk("gnt1", m1_gnt, (g == 1));
        exp_wr = !rst && (mbusy || (g >= 0 && q_we[g] && q_be[g] == 4'hF));
        chk("ram_wr", ram_wr, exp_wr);
        if (!rst && mbusy) begin
            chk("merge_addr", ram_addr, pend_addr);
            chk("merge_din", ram_din, pend_data);
        end else if (g >= 0 && !(q_we[g] && q_be[g] == 4'h0)) begin
            chk("acc_addr", ram_addr, q_addr[g]);
            if (exp_wr) chk("acc_din", ram_din, q_wdata[g]);
        end
        chk("rvalid0", m0_rvalid, exp_rv[0] && !rst);
        chk("rvalid1", m1_rvalid, exp_rv[1] && !rst);
        chk("rdata0", m0_rdata, (exp_rv[0] && !rst) ? exp_rd[0] : hold[0]);
        chk("rdata1", m1_rdata, (exp_rv[1] && !rst) ? exp_rd[1] : hold[1]);

        if (rst) begin
            mbusy = 1'b0; mlast = 1;
            exp_rv = '{1'b0, 1'b0};
            hold = '{32'h0, 32'h0};
        end else begin
            for (int m = 0; m < 2; m++) if (exp_rv[m]) hold[m] = exp_rd[m];
            exp_rv = '{1'b0, 1'b0};
            if (mbusy) begin
                smem[pend_addr[3:0]] = pend_data;
                mbusy = 1'b0;
            end else if (g >= 0) begin
                mlast = g;
                if (!q_we[g]) begin
                    exp_rv[g] = 1'b1;
                    exp_rd[g] = smem[q_addr[g][3:0]];
                end else if (q_be[g] == 4'hF) begin
                    smem[q_addr[g][3:0]] = q_wdata[g];
                end else if (q_be[g] != 4'h0) begin
                    mask = '0;
                    for (int k = 0; k < 4; k++) if (q_be[g][k]) mask[8*k +: 8] = 8'hFF;
                    pend_addr = q_addr[g];
                    pend_data = (q_wdata[g] & mask) | (smem[q_addr[g][3:0]] & ~mask);
                    mbusy = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (g >= 0) q_req[g] = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        for (int m = 0; m < 2; m++) set_req(m, 1'b0, 4'h0, 10'd0, 32'h0);
        q_req[0] = 1'b0; q_req[1] = 1'b0;
        mbusy = 1'b0; mlast = 1; pend_addr = '0; pend_data = '0;
        exp_rv = '{1'b0, 1'b0}; exp_rd = '{32'h0, 32'h0}; hold = '{32'h0, 32'h0};

        for (int i = 0; i < 16; i++) begin
            v = (32'h0101_0101 * i) ^ 32'hC3C3_0000;
            if (i == 4) v = 32'hAABBCCDD;
            if (i == 5) v = 32'hDEADBEEF;
            if (i == 6) v = 32'h00000055;
            smem[i] = v;
            ld_we = 1'b1; ld_addr = 4'(i); ld_data = v;
            @(posedge clk);
            #1;
        end
        ld_we = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("rst_ram_addr", ram_addr, 10'd0);
        chk("rst_ram_din", ram_din, 32'h0);

        set_req(0, 1'b0, 4'h0, 10'd5, 32'h0);
        cycle();
        cycle();
        chk("rd5_hold", m0_rdata, 32'hDEADBEEF);

        for (int i = 0; i < 8; i++) begin
            if (!q_req[0]) set_req(0, 1'b0, 4'h0, 10'd1, 32'h0);
            if (!q_req[1]) set_req(1, 1'b0, 4'h0, 10'd2, 32'h0);
            cycle();
        end
        q_req[0] = 1'b0; q_req[1] = 1'b0;
        cycle();

        set_req(1, 1'b1, 4'hF, 10'd3, 32'h12345678);
        cycle();
        set_req(0, 1'b0, 4'h0, 10'd3, 32'h0);
        cycle();
        cycle();
        chk("wr3_rd", m0_rdata, 32'h12345678);

        set_req(1, 1'b1, 4'b0101, 10'd4, 32'h11223344);
        cycle();
        set_req(0, 1'b0, 4'h0, 10'd4, 32'h0);
        cycle();
        cycle();
        cycle();
        chk("rmw4_rd", m0_rdata, 32'hAA22CC44);

        set_req(0, 1'b1, 4'h0, 10'd6, 32'hFFFF_FFFF);
        cycle();
        set_req(0, 1'b0, 4'h0, 10'd6, 32'h0);
        cycle();
        cycle();
        chk("be0_rd6", m0_rdata, 32'h00000055);

        set_req(1, 1'b1, 4'b0011, 10'd7, 32'h0BAD_F00D);
        cycle();
        rst = 1'b1;
        set_req(0, 1'b0, 4'h0, 10'd1, 32'h0);
        set_req(1, 1'b0, 4'h0, 10'd2, 32'h0);
        cycle();
        rst = 1'b0;
        #2;
        chk("tie_after_rst", m0_gnt, 1'b1);
        cycle();
        cycle();
        cycle();

        for (int i = 0; i < 400; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (!q_req[m] && $urandom_range(0, 2) != 0) rand_req(m);
            end
            rst = ($urandom_range(0, 79) == 0);
            cycle();
        end
        rst = 1'b0;
        q_req[0] = 1'b0; q_req[1] = 1'b0;
        cycle();
        cycle();
        cycle();

        for (int i = 0; i < 16; i++) chk($sformatf("mem%0d", i), mem[i], smem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
